// File: rtl/baby_display_shadow.sv
// rtl/baby_display_shadow.sv - shadow copy of the processor store/ACC with a registered renderer read port
// Optional row-write highlight counters enabled by BABY_HIGHLIGHT_EN.
module baby_display_shadow #(
    parameter int ROWS      = 32,
    parameter int WIDTH     = 32,
    parameter int CNT_W     = 16,
    parameter int HL_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             update,
    input  logic [WIDTH-1:0] updatedata,
    input  logic [4:0]       updateaddr,
    input  logic             updateACC,
    input  logic [WIDTH-1:0] newACC,
    input  logic [4:0]       rCI,
    input  logic             rd_en,
    input  logic [4:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_is_ci,
    output logic [WIDTH-1:0] acc_out,
    output logic [4:0]       ci_out,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] acc_count,
    output logic             rd_hl
);

    logic [WIDTH-1:0] shadow_q [ROWS];
    logic             upd_q, acc_q;
    logic [WIDTH-1:0] acc_out_q, acc_out_d;
    logic [4:0]       ci_out_q;
    logic [CNT_W-1:0] wr_count_q, wr_count_d;
    logic [CNT_W-1:0] acc_count_q, acc_count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q;
    logic             rd_is_ci_q, rd_is_ci_d;
    logic             wr_ev, acc_ev, same_row, hl_hit;

    // A level change on either toggle line is one event; consecutive toggles are never merged.
    always_comb begin
        wr_ev       = (update != upd_q);
        acc_ev      = (updateACC != acc_q);
        same_row    = wr_ev && (updateaddr == rd_addr);
        wr_count_d  = wr_ev  ? wr_count_q + CNT_W'(1)  : wr_count_q;
        acc_count_d = acc_ev ? acc_count_q + CNT_W'(1) : acc_count_q;
        acc_out_d   = acc_ev ? newACC : acc_out_q;
        rd_data_d   = rd_data_q;
        rd_is_ci_d  = rd_is_ci_q;
        if (rd_en) begin
            rd_data_d  = same_row ? updatedata : shadow_q[rd_addr];
            rd_is_ci_d = (rd_addr == rCI);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ROWS; i++) begin
                shadow_q[i] <= '0;
            end
            upd_q       <= update;
            acc_q       <= updateACC;
            acc_out_q   <= '0;
            ci_out_q    <= '0;
            wr_count_q  <= '0;
            acc_count_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_is_ci_q  <= 1'b0;
        end else begin
            if (wr_ev) begin
                shadow_q[updateaddr] <= updatedata;
            end
            upd_q       <= update;
            acc_q       <= updateACC;
            acc_out_q   <= acc_out_d;
            ci_out_q    <= rCI;
            wr_count_q  <= wr_count_d;
            acc_count_q <= acc_count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_en;
            rd_is_ci_q  <= rd_is_ci_d;
        end
    end

`ifdef BABY_HIGHLIGHT_EN
    logic [7:0] hl_q [ROWS];
    logic       rd_hl_q;

    // Same-row write wins over the stored counter so a fresh write reads as highlighted.
    assign hl_hit = same_row || (hl_q[rd_addr] != 8'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ROWS; i++) begin
                hl_q[i] <= 8'd0;
            end
            rd_hl_q <= 1'b0;
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                if (wr_ev && (updateaddr == 5'(i))) begin
                    hl_q[i] <= 8'(HL_CYCLES);
                end else if (hl_q[i] != 8'd0) begin
                    hl_q[i] <= hl_q[i] - 8'd1;
                end
            end
            if (rd_en) begin
                rd_hl_q <= hl_hit;
            end
        end
    end

    assign rd_hl = rd_hl_q;
`else
    logic [7:0] unused_hl_cycles;
    assign unused_hl_cycles = 8'(HL_CYCLES);
    assign hl_hit           = 1'b0;
    assign rd_hl            = hl_hit;
`endif

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_is_ci  = rd_is_ci_q;
    assign acc_out   = acc_out_q;
    assign ci_out    = ci_out_q;
    assign wr_count  = wr_count_q;
    assign acc_count = acc_count_q;

endmodule

// File: tb/tb_baby_display_shadow.sv
// tb/tb_baby_display_shadow.sv - directed plus randomized bench for baby_display_shadow against an array model
module tb_baby_display_shadow;

    localparam int HLC = 4;

    logic        clk = 1'b0;
    logic        reset, update, updateACC, rd_en;
    logic [31:0] updatedata, newACC;
    logic [4:0]  updateaddr, rCI, rd_addr;
    logic [31:0] rd_data, acc_out;
    logic        rd_valid, rd_is_ci, rd_hl;
    logic [4:0]  ci_out;
    logic [15:0] wr_count, acc_count;

    always #5 clk = ~clk;

    baby_display_shadow #(.ROWS(32), .WIDTH(32), .CNT_W(16), .HL_CYCLES(HLC)) dut (
        .clk(clk), .reset(reset), .update(update), .updatedata(updatedata),
        .updateaddr(updateaddr), .updateACC(updateACC), .newACC(newACC), .rCI(rCI),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_is_ci(rd_is_ci), .acc_out(acc_out), .ci_out(ci_out), .wr_count(wr_count),
        .acc_count(acc_count), .rd_hl(rd_hl)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [32];
    int          m_hlc [32];
    logic [31:0] m_acc, m_rd;
    int          m_wr, m_accc;
    logic [4:0]  m_ci;
    logic        m_valid, m_isci, m_hl, m_pu, m_pa;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Applies this cycle's inputs to the model, advances one clock and compares every output.
    task automatic step();
        logic w, a;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i] = '0;
                m_hlc[i] = 0;
            end
            m_acc = '0; m_rd = '0; m_wr = 0; m_accc = 0; m_ci = '0;
            m_valid = 1'b0; m_isci = 1'b0; m_hl = 1'b0;
        end else begin
            w = (update !== m_pu);
            a = (updateACC !== m_pa);
            if (rd_en) begin
                m_rd   = (w && updateaddr == rd_addr) ? updatedata : m_mem[rd_addr];
                m_isci = (rd_addr == rCI);
`ifdef BABY_HIGHLIGHT_EN
                m_hl   = (w && updateaddr == rd_addr) || (m_hlc[rd_addr] > 0);
`else
                m_hl   = 1'b0;
`endif
            end
            m_valid = rd_en;
            for (int i = 0; i < 32; i++) begin
                if (w && updateaddr == 5'(i)) m_hlc[i] = HLC;
                else if (m_hlc[i] > 0) m_hlc[i] = m_hlc[i] - 1;
            end
            if (w) begin
                m_mem[updateaddr] = updatedata;
                m_wr = (m_wr + 1) % 65536;
            end
            if (a) begin
                m_acc  = newACC;
                m_accc = (m_accc + 1) % 65536;
            end
            m_ci = rCI;
        end
        m_pu = update;
        m_pa = updateACC;
        @(posedge clk);
        #1;
        check("rd_valid", {31'd0, rd_valid}, {31'd0, m_valid});
        check("rd_data", rd_data, m_rd);
        check("rd_is_ci", {31'd0, rd_is_ci}, {31'd0, m_isci});
        check("rd_hl", {31'd0, rd_hl}, {31'd0, m_hl});
        check("acc_out", acc_out, m_acc);
        check("ci_out", {27'd0, ci_out}, {27'd0, m_ci});
        check("wr_count", {16'd0, wr_count}, 32'(m_wr));
        check("acc_count", {16'd0, acc_count}, 32'(m_accc));
    endtask

    initial begin
        reset = 1'b1; update = 1'b0; updateACC = 1'b0; rd_en = 1'b0;
        updatedata = '0; newACC = '0; updateaddr = '0; rCI = '0; rd_addr = '0;
        m_pu = 1'b0; m_pa = 1'b0;
        step();
        // Toggle lines rise while reset is held: must not count as events.
        update = 1'b1; updateACC = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("reset_wr_count", {16'd0, wr_count}, 32'd0);
        check("reset_acc_count", {16'd0, acc_count}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            rd_en = 1'b1; rd_addr = 5'(i);
            step();
        end
        check("reset_row31", rd_data, 32'd0);

        rd_en = 1'b0; updateaddr = 5'd5; updatedata = 32'hDEADBEEF; update = ~update;
        step();
        rd_en = 1'b1; rd_addr = 5'd5;
        step();
        check("t2_data", rd_data, 32'hDEADBEEF);
        check("t2_valid", {31'd0, rd_valid}, 32'd1);
        check("t2_wr_count", {16'd0, wr_count}, 32'd1);
        rd_en = 1'b0;
        step();
        check("t2_valid_pulse", {31'd0, rd_valid}, 32'd0);
        check("t2_hold", rd_data, 32'hDEADBEEF);

        updateaddr = 5'd31; updatedata = 32'd1; newACC = -32'sd7;
        update = ~update; updateACC = ~updateACC;
        step();
        check("t3_acc", acc_out, 32'hFFFFFFF9);
        check("t3_wr_count", {16'd0, wr_count}, 32'd2);
        check("t3_acc_count", {16'd0, acc_count}, 32'd1);
        rd_en = 1'b1; rd_addr = 5'd31;
        step();
        check("t3_row31", rd_data, 32'd1);

        rd_addr = 5'd9; updateaddr = 5'd9; updatedata = 32'h12345678; rCI = 5'd9;
        update = ~update;
        step();
        check("t4_write_first", rd_data, 32'h12345678);
        check("t4_is_ci", {31'd0, rd_is_ci}, 32'd1);
        rCI = 5'd10;
        step();
        check("t4_not_ci", {31'd0, rd_is_ci}, 32'd0);
        check("t4_ci_out", {27'd0, ci_out}, 32'd10);

        rd_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            updateaddr = 5'(i); updatedata = 32'hA0 + 32'(i); update = ~update;
            step();
        end
        check("t5_wr_count", {16'd0, wr_count}, 32'd6);
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1; rd_addr = 5'(i);
            step();
            check("t5_row", rd_data, 32'hA0 + 32'(i));
        end

        rd_en = 1'b0; updateaddr = 5'd3; updatedata = 32'h33; update = ~update;
        step();
        rd_en = 1'b1; rd_addr = 5'd3;
        step();
`ifdef BABY_HIGHLIGHT_EN
        check("t6_hl_on", {31'd0, rd_hl}, 32'd1);
`else
        check("t6_hl_tied", {31'd0, rd_hl}, 32'd0);
`endif
        rd_en = 1'b0;
        repeat (4) step();
        rd_en = 1'b1;
        step();
        check("t6_hl_off", {31'd0, rd_hl}, 32'd0);
        rd_en = 1'b0; update = ~update;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; rd_en = 1'b1;
        step();
        check("t6_reset_hl", {31'd0, rd_hl}, 32'd0);
        check("t6_reset_row3", rd_data, 32'd0);

        for (int n = 0; n < 2000; n++) begin
            reset      = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 1) == 1) update = ~update;
            if ($urandom_range(0, 2) == 0) updateACC = ~updateACC;
            updatedata = $urandom;
            newACC     = $urandom;
            updateaddr = 5'($urandom_range(0, 31));
            rCI        = 5'($urandom_range(0, 31));
            rd_en      = ($urandom_range(0, 1) == 1);
            rd_addr    = ($urandom_range(0, 3) == 0) ? updateaddr : 5'($urandom_range(0, 31));
            step();
        end

        reset = 1'b1; rd_en = 1'b0;
        step();
        reset = 1'b0;
        for (int n = 0; n < 65537; n++) begin
            update = ~update;
            updatedata = 32'(n);
            step();
        end
        check("wrap_wr_count", {16'd0, wr_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
